anita3_trigger_scheduler: RTL and testbench

- Arbitrates up to NSRC trigger sources (RF L3, PPS, software, external) onto the single board trigger.
- Issues a one-cycle trigger pulse with the winning source ID.
- Then enforces a programmable holdoff window, followed by an optional wait for digitizer-ready.
- Sits between the per-source trigger logic and the readout/holdoff path; also reports issued and lost trigger counts for housekeeping.

---
 rtl/anita3_trigger_pkg.sv | 20 ++
 rtl/anita3_rr_arbiter.sv | 35 +++
 rtl/anita3_trigger_scheduler.sv | 146 ++++++++++++++
 tb/tb_anita3_trigger_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anita3_trigger_pkg.sv
// Shared definitions for the ANITA-3 board trigger scheduler.
package anita3_trigger_pkg;

  localparam int NSRC_DEF      = 4;
  localparam int HOLDOFF_W_DEF = 8;
  localparam int CNT_W_DEF     = 16;

  localparam int SRC_RF   = 0;
  localparam int SRC_PPS  = 1;
  localparam int SRC_SOFT = 2;
  localparam int SRC_EXT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FIRE       = 2'd1,
    ST_HOLDOFF    = 2'd2,
    ST_WAIT_READY = 2'd3
  } sched_state_e;

endpackage

// File: rtl/anita3_rr_arbiter.sv
// Combinational round-robin arbiter: search begins just after the last grant.
module anita3_rr_arbiter
  import anita3_trigger_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  localparam int IDX_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [NSRC-1:0]  grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_grant_o
);

  logic [IDX_W-1:0] cand_s;

  // Walk the sources in rotated order and take the first requester.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    cand_s      = '0;
    for (int i = 1; i <= NSRC; i++) begin
      cand_s = IDX_W'((int'(last_grant_i) + i) % NSRC);
      if (!any_grant_o && req_i[cand_s]) begin
        grant_oh_o[cand_s] = 1'b1;
        grant_idx_o        = cand_s;
        any_grant_o        = 1'b1;
      end else begin
        grant_oh_o = grant_oh_o;
      end
    end
  end

endmodule

// File: rtl/anita3_trigger_scheduler.sv
// Board trigger scheduler: edge detect, round-robin grant, fire pulse,
// holdoff window, optional wait for digitizer ready, housekeeping counters.
module anita3_trigger_scheduler
  import anita3_trigger_pkg::*;
#(
  parameter int NSRC      = NSRC_DEF,
  parameter int HOLDOFF_W = HOLDOFF_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  localparam int IDX_W    = $clog2(NSRC)
) (
  input  logic                 clk250_i,
  input  logic                 rst_n_i,
  input  logic [NSRC-1:0]      trig_req_i,
  input  logic [NSRC-1:0]      trig_en_i,
  input  logic [HOLDOFF_W-1:0] holdoff_len_i,
  input  logic                 busy_i,
  output logic                 trig_o,
  output logic [IDX_W-1:0]     trig_src_o,
  output logic                 holdoff_o,
  output logic [CNT_W-1:0]     trig_count_o,
  output logic [CNT_W-1:0]     lost_count_o
);

  localparam logic [HOLDOFF_W:0] HCNT_ONE = {{HOLDOFF_W{1'b0}}, 1'b1};
  localparam logic [HOLDOFF_W:0] HCNT_MIN = {{(HOLDOFF_W-1){1'b0}}, 2'b10};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  sched_state_e         state_q, state_d;
  logic [NSRC-1:0]      req_q, req_d;
  logic [NSRC-1:0]      edge_s;
  logic [HOLDOFF_W:0]   hcnt_q, hcnt_d, hload_s;
  logic [IDX_W-1:0]     src_q, src_d, last_q, last_d;
  logic [CNT_W-1:0]     tcnt_q, tcnt_d, lcnt_q, lcnt_d;
  logic                 trig_q, trig_d, hold_q, hold_d;
  logic [NSRC-1:0]      goh_s;
  logic [IDX_W-1:0]     gidx_s;
  logic                 gany_s;
  logic                 drop_s;

  anita3_rr_arbiter #(.NSRC(NSRC)) u_arb (
    .req_i        (edge_s),
    .last_grant_i (last_q),
    .grant_oh_o   (goh_s),
    .grant_idx_o  (gidx_s),
    .any_grant_o  (gany_s)
  );

  // Rising-edge detect on enabled sources; holdoff length 0 acts as 1.
  always_comb begin
    req_d  = trig_req_i;
    edge_s = trig_req_i & ~req_q & trig_en_i;
    if (holdoff_len_i == '0) begin
      hload_s = HCNT_MIN;
    end else begin
      hload_s = {holdoff_len_i, 1'b0};
    end
  end

  // Next state, grant capture, holdoff countdown and counter updates.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    src_d   = src_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    lcnt_d  = lcnt_q;
    // In IDLE only the non-granted edges are lost; elsewhere every edge is.
    if (state_q == ST_IDLE) begin
      drop_s = |(edge_s & ~goh_s);
    end else begin
      drop_s = |edge_s;
    end
    case (state_q)
      ST_IDLE: begin
        if (gany_s) begin
          state_d = ST_FIRE;
          src_d   = gidx_s;
          last_d  = gidx_s;
          hcnt_d  = hload_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FIRE: begin
        tcnt_d  = tcnt_q + CNT_ONE;
        state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hcnt_q <= HCNT_ONE) begin
          state_d = busy_i ? ST_WAIT_READY : ST_IDLE;
        end else begin
          hcnt_d = hcnt_q - HCNT_ONE;
        end
      end
      ST_WAIT_READY: begin
        if (!busy_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_READY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (drop_s) begin
      lcnt_d = lcnt_q + CNT_ONE;
    end else begin
      lcnt_d = lcnt_d;
    end
    trig_d = (state_d == ST_FIRE);
    hold_d = (state_d != ST_IDLE);
  end

  // State and output registers; request history resets high so held levels never fire.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      req_q   <= '1;
      hcnt_q  <= '0;
      src_q   <= '0;
      last_q  <= IDX_W'(NSRC - 1);
      tcnt_q  <= '0;
      lcnt_q  <= '0;
      trig_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      hcnt_q  <= hcnt_d;
      src_q   <= src_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      lcnt_q  <= lcnt_d;
      trig_q  <= trig_d;
      hold_q  <= hold_d;
    end
  end

  assign trig_o       = trig_q;
  assign trig_src_o   = src_q;
  assign holdoff_o    = hold_q;
  assign trig_count_o = tcnt_q;
  assign lost_count_o = lcnt_q;

endmodule

// File: tb/tb_anita3_trigger_scheduler.sv
// Self-checking bench for anita3_trigger_scheduler: directed table, corner
// sequences and randomized traffic against a timeline-based reference model.
module tb_anita3_trigger_scheduler;
  import anita3_trigger_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [3:0]  trig_req_i;
  logic [3:0]  trig_en_i;
  logic [7:0]  holdoff_len_i;
  logic        busy_i;
  logic        trig_o;
  logic [1:0]  trig_src_o;
  logic        holdoff_o;
  logic [15:0] trig_count_o;
  logic [15:0] lost_count_o;

  anita3_trigger_scheduler dut (
    .clk250_i      (clk),
    .rst_n_i       (rst_n_i),
    .trig_req_i    (trig_req_i),
    .trig_en_i     (trig_en_i),
    .holdoff_len_i (holdoff_len_i),
    .busy_i        (busy_i),
    .trig_o        (trig_o),
    .trig_src_o    (trig_src_o),
    .holdoff_o     (holdoff_o),
    .trig_count_o  (trig_count_o),
    .lost_count_o  (lost_count_o)
  );

  always #2 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a timeline of "free from cycle X" plus a ready-wait flag.
  logic [3:0] m_prev;
  int m_last, m_src, m_tc, m_lc, m_pend, m_free, m_dec;
  bit m_wait, m_trig, m_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prev = 4'hF; m_last = 3; m_src = 0; m_tc = 0; m_lc = 0; m_pend = 0;
    m_free = 0; m_dec = -10; m_wait = 1'b0; m_trig = 1'b0; m_hold = 1'b0;
  endtask

  task automatic model_edge();
    bit idle;
    logic [3:0] edges;
    int g, c, leff;
    idle   = !m_wait && (cyc >= m_free);
    edges  = trig_req_i & ~m_prev & trig_en_i;
    m_prev = trig_req_i;
    m_tc   = m_tc + m_pend;
    m_pend = 0;
    m_trig = 1'b0;
    if (edges != 4'd0) begin
      if (idle) begin
        g = -1;
        for (int i = 1; i <= 4; i++) begin
          c = (m_last + i) % 4;
          if (g < 0 && edges[c]) g = c;
        end
        m_src = g; m_last = g;
        if ($countones(edges) > 1) m_lc++;
        leff   = (holdoff_len_i == 8'd0) ? 1 : int'(holdoff_len_i);
        m_dec  = cyc + 2 * leff + 1;
        m_free = m_dec + 1;
        m_pend = 1;
        m_trig = 1'b1;
      end else begin
        m_lc++;
      end
    end
    if (cyc == m_dec && busy_i) begin
      m_wait = 1'b1;
    end else if (m_wait && cyc > m_dec && !busy_i) begin
      m_wait = 1'b0;
      m_free = cyc + 1;
    end
    m_hold = m_wait || (cyc + 1 < m_free);
  endtask

  // One clock: update model at the edge, compare all outputs 1 ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("trig_o", 32'(trig_o), 32'(m_trig));
    chk("trig_src_o", 32'(trig_src_o), 32'(m_src));
    chk("holdoff_o", 32'(holdoff_o), 32'(m_hold));
    chk("trig_count_o", 32'(trig_count_o), 32'(m_tc & 16'hFFFF));
    chk("lost_count_o", 32'(lost_count_o), 32'(m_lc & 16'hFFFF));
  endtask

  task automatic idle_out(input int n);
    trig_req_i = 4'd0;
    busy_i     = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic [3:0] en;
    logic [3:0] req;
    logic [7:0] len;
    logic       exp_trig;
    logic [1:0] exp_src;
    int         exp_lost;
  } vec_t;

  vec_t tab[9];

  initial begin
    int lost0, hcnt, tcnt0, tpulses;

    tab[0] = '{4'hF, 4'b0100, 8'd2, 1'b1, 2'd2, 0};
    tab[1] = '{4'hF, 4'b1011, 8'd1, 1'b1, 2'd3, 1};
    tab[2] = '{4'hF, 4'b1011, 8'd3, 1'b1, 2'd0, 1};
    tab[3] = '{4'hF, 4'b1011, 8'd1, 1'b1, 2'd1, 1};
    tab[4] = '{4'hF, 4'b1011, 8'd2, 1'b1, 2'd3, 1};
    tab[5] = '{4'hF, 4'b1011, 8'd1, 1'b1, 2'd0, 1};
    tab[6] = '{4'hD, 4'b0010, 8'd1, 1'b0, 2'd0, 0};
    tab[7] = '{4'hD, 4'b0011, 8'd1, 1'b1, 2'd0, 0};
    tab[8] = '{4'hF, 4'b1000, 8'd2, 1'b1, 2'd3, 0};

    rst_n_i = 1'b0; trig_req_i = 4'd0; trig_en_i = 4'hF;
    holdoff_len_i = 8'd4; busy_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset trig_o", 32'(trig_o), 32'd0);
    chk("reset holdoff_o", 32'(holdoff_o), 32'd0);
    chk("reset trig_count", 32'(trig_count_o), 32'd0);
    chk("reset lost_count", 32'(lost_count_o), 32'd0);
    rst_n_i = 1'b1;
    idle_out(8);

    // Single source, L=4: one pulse from src2, holdoff high for 9 cycles.
    tcnt0 = int'(trig_count_o);
    holdoff_len_i = 8'd4;
    trig_req_i = 4'b0000;
    trig_req_i[SRC_SOFT] = 1'b1;
    hcnt = 0; tpulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (holdoff_o) hcnt++;
      if (trig_o) tpulses++;
      if (i == 0) chk("single src", 32'(trig_src_o), 32'(SRC_SOFT));
    end
    chk("single holdoff len", 32'(hcnt), 32'd9);
    chk("single pulses", 32'(tpulses), 32'd1);
    chk("single count", 32'(trig_count_o), 32'(tcnt0 + 1));
    idle_out(2);

    // Table: fire from an idle, all-low request state and check grant/loss.
    for (int k = 0; k < 9; k++) begin
      lost0 = int'(lost_count_o);
      trig_en_i = tab[k].en;
      holdoff_len_i = tab[k].len;
      trig_req_i = tab[k].req;
      step();
      chk($sformatf("tab%0d trig", k), 32'(trig_o), 32'(tab[k].exp_trig));
      if (tab[k].exp_trig) chk($sformatf("tab%0d src", k), 32'(trig_src_o), 32'(tab[k].exp_src));
      chk($sformatf("tab%0d lost", k), 32'(lost_count_o), 32'(lost0 + tab[k].exp_lost));
      idle_out(2 * int'(tab[k].len) + 6);
    end
    trig_en_i = 4'hF;

    // Edge during holdoff is lost; a fresh edge right after holdoff fires.
    holdoff_len_i = 8'd2;
    lost0 = int'(lost_count_o);
    trig_req_i = 4'b0001;
    step();
    chk("hold fire", 32'(trig_o), 32'd1);
    step(); step();
    trig_req_i = 4'b0011;
    step();
    chk("hold no trig", 32'(trig_o), 32'd0);
    chk("hold lost", 32'(lost_count_o), 32'(lost0 + 1));
    hcnt = 0;
    while (holdoff_o && hcnt < 40) begin step(); hcnt++; end
    chk("hold fell", 32'(holdoff_o), 32'd0);
    trig_req_i = 4'b0111;
    step();
    chk("post hold trig", 32'(trig_o), 32'd1);
    chk("post hold src", 32'(trig_src_o), 32'd2);
    idle_out(10);

    // busy held 20 cycles past holdoff end with L=1.
    holdoff_len_i = 8'd1;
    busy_i = 1'b1;
    trig_req_i = 4'b1000;
    step();
    chk("busy fire", 32'(trig_o), 32'd1);
    step(); step(); step();
    tpulses = 0;
    for (int i = 0; i < 20; i++) begin
      trig_req_i[0] = ~trig_req_i[0];
      step();
      if (trig_o) tpulses++;
      chk("busy holdoff", 32'(holdoff_o), 32'd1);
    end
    chk("busy no trig", 32'(tpulses), 32'd0);
    busy_i = 1'b0;
    step();
    chk("busy release", 32'(holdoff_o), 32'd0);
    idle_out(4);

    // Disabled source toggling is invisible; len 0 behaves as len 1.
    trig_en_i = 4'b1101;
    lost0 = int'(lost_count_o);
    tpulses = 0;
    for (int i = 0; i < 10; i++) begin
      trig_req_i[1] = ~trig_req_i[1];
      step();
      if (trig_o) tpulses++;
    end
    chk("disabled no trig", 32'(tpulses), 32'd0);
    chk("disabled lost", 32'(lost_count_o), 32'(lost0));
    holdoff_len_i = 8'd0;
    trig_req_i = 4'b0001;
    hcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (holdoff_o) hcnt++;
    end
    chk("len0 holdoff", 32'(hcnt), 32'd3);
    trig_en_i = 4'hF;
    idle_out(4);

    // Reset mid-holdoff, levels held high through release.
    holdoff_len_i = 8'd8;
    trig_req_i = 4'b0010;
    step();
    trig_req_i = 4'hF;
    for (int i = 0; i < 5; i++) step();
    rst_n_i = 1'b0;
    #1;
    chk("rst trig_o", 32'(trig_o), 32'd0);
    chk("rst src", 32'(trig_src_o), 32'd0);
    chk("rst holdoff", 32'(holdoff_o), 32'd0);
    chk("rst tcount", 32'(trig_count_o), 32'd0);
    chk("rst lcount", 32'(lost_count_o), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    tpulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (trig_o) tpulses++;
    end
    chk("held level no trig", 32'(tpulses), 32'd0);
    trig_req_i = 4'd0;
    step();
    trig_req_i = 4'hF;
    step();
    chk("after rst trig", 32'(trig_o), 32'd1);
    chk("after rst src0", 32'(trig_src_o), 32'(SRC_RF));
    idle_out(20);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) trig_req_i = 4'($urandom);
      if ($urandom_range(0, 15) == 0) trig_en_i = 4'($urandom) | 4'b0001;
      if ($urandom_range(0, 7) == 0) busy_i = ($urandom_range(0, 2) == 0);
      holdoff_len_i = 8'($urandom_range(0, 5));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
